// File: rtl/some_module.sv
// Event counter with terminal-count compare; one-shot (stop and flag done)
// or auto-reload (wrap to zero) selected by SOME_BIT_PARAM.
module some_module #(
    parameter bit SOME_BIT_PARAM       = 1'b0,
    parameter int SOME_OTHER_INT_PARAM = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic       clr,
    output logic [7:0] count,
    output logic       hit,
    output logic       done,
    output logic       missed
);

    // State of the done flag:
    //   done | meaning
    //   0    | counting toward terminal count (always 0 in auto-reload)
    //   1    | one-shot terminal reached; count parked at T, events flag missed
    generate
        if (SOME_OTHER_INT_PARAM < 1 || SOME_OTHER_INT_PARAM > 255) begin : g_bad_term
            $error("some_module: SOME_OTHER_INT_PARAM must be in 1..255");
        end
    endgenerate

    localparam logic [7:0] TERM    = SOME_OTHER_INT_PARAM[7:0];
    localparam logic [7:0] TERM_M1 = TERM - 8'd1;

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            count  <= 8'd0;
            hit    <= 1'b0;
            done   <= 1'b0;
            missed <= 1'b0;
        end else begin
            hit <= 1'b0;
            if (en) begin
                if (done) begin
                    missed <= 1'b1;
                end else if (count == TERM_M1) begin
                    hit <= 1'b1;
                    if (SOME_BIT_PARAM) begin
                        count <= 8'd0;
                    end else begin
                        count <= TERM;
                        done  <= 1'b1;
                    end
                end else begin
                    count <= count + 8'd1;
                end
            end
        end
    end

endmodule

// File: tb/tb_some_module.sv
// Directed bench for some_module: four instances cover both modes at T=18 and T=1,
// sharing clock and stimulus.
module tb_some_module;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic en  = 1'b0;
    logic clr = 1'b0;

    logic [7:0] c_a, c_b, c_c, c_d;
    logic       h_a, h_b, h_c, h_d;
    logic       d_a, d_b, d_c, d_d;
    logic       m_a, m_b, m_c, m_d;

    int vectors = 0;
    int errors  = 0;

    always #5 clk = ~clk;

    // a: auto-reload T=18, b: one-shot T=18, c: auto-reload T=1, d: one-shot T=1
    some_module #(.SOME_BIT_PARAM(1'b1), .SOME_OTHER_INT_PARAM(18)) u_a (
        .clk(clk), .rst(rst), .en(en), .clr(clr),
        .count(c_a), .hit(h_a), .done(d_a), .missed(m_a));
    some_module #(.SOME_BIT_PARAM(1'b0), .SOME_OTHER_INT_PARAM(18)) u_b (
        .clk(clk), .rst(rst), .en(en), .clr(clr),
        .count(c_b), .hit(h_b), .done(d_b), .missed(m_b));
    some_module #(.SOME_BIT_PARAM(1'b1), .SOME_OTHER_INT_PARAM(1)) u_c (
        .clk(clk), .rst(rst), .en(en), .clr(clr),
        .count(c_c), .hit(h_c), .done(d_c), .missed(m_c));
    some_module #(.SOME_BIT_PARAM(1'b0), .SOME_OTHER_INT_PARAM(1)) u_d (
        .clk(clk), .rst(rst), .en(en), .clr(clr),
        .count(c_d), .hit(h_d), .done(d_d), .missed(m_d));

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; clr = 1'b0; en = 1'b0;
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; clr = 1'b1; en = 1'b1;
        tick();
        rst = 1'b0; clr = 1'b0; en = 1'b0;
        vectors++;
        if ({c_a, h_a, d_a, m_a} !== 11'd0) begin
            errors++;
            $display("FAIL reset_a got=%h exp=000", {c_a, h_a, d_a, m_a});
        end
        vectors++;
        if ({c_b, h_b, d_b, m_b} !== 11'd0) begin
            errors++;
            $display("FAIL reset_b got=%h exp=000", {c_b, h_b, d_b, m_b});
        end
        vectors++;
        if ({c_d, h_d, d_d, m_d} !== 11'd0) begin
            errors++;
            $display("FAIL reset_d got=%h exp=000", {c_d, h_d, d_d, m_d});
        end
    endtask

    task automatic test_auto_reload();
        logic [7:0] ec;
        logic       eh;
        do_reset();
        en = 1'b1;
        for (int i = 1; i <= 40; i++) begin
            tick();
            ec = 8'(i % 18);
            eh = (i % 18 == 0);
            vectors++;
            if ({c_a, h_a, d_a, m_a} !== {ec, eh, 1'b0, 1'b0}) begin
                errors++;
                $display("FAIL auto_reload cyc=%0d got c=%0d h=%b d=%b m=%b exp c=%0d h=%b d=0 m=0",
                         i, c_a, h_a, d_a, m_a, ec, eh);
            end
        end
        en = 1'b0;
    endtask

    task automatic test_one_shot();
        logic [7:0] ec;
        do_reset();
        en = 1'b1;
        for (int i = 1; i <= 25; i++) begin
            tick();
            ec = (i >= 18) ? 8'd18 : 8'(i);
            vectors++;
            if ({c_b, h_b, d_b, m_b} !== {ec, (i == 18), (i >= 18), (i >= 19)}) begin
                errors++;
                $display("FAIL one_shot cyc=%0d got c=%0d h=%b d=%b m=%b exp c=%0d h=%b d=%b m=%b",
                         i, c_b, h_b, d_b, m_b, ec, (i == 18), (i >= 18), (i >= 19));
            end
        end
        en = 1'b0;
    endtask

    task automatic test_clear();
        // relies on u_b being done and missed from test_one_shot
        clr = 1'b1; en = 1'b1;
        tick();
        clr = 1'b0;
        vectors++;
        if ({c_b, h_b, d_b, m_b} !== 11'd0) begin
            errors++;
            $display("FAIL clear got c=%0d h=%b d=%b m=%b exp all 0", c_b, h_b, d_b, m_b);
        end
        tick();
        en = 1'b0;
        vectors++;
        if ({c_b, h_b, d_b, m_b} !== {8'd1, 3'b000}) begin
            errors++;
            $display("FAIL clear_next got c=%0d h=%b d=%b m=%b exp c=1 h=0 d=0 m=0", c_b, h_b, d_b, m_b);
        end
    endtask

    task automatic test_reset_mid();
        int hits;
        do_reset();
        en = 1'b1;
        for (int i = 0; i < 17; i++) tick();
        vectors++;
        if (c_a !== 8'd17) begin
            errors++;
            $display("FAIL pre_rst_count got=%0d exp=17", c_a);
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        vectors++;
        if ({c_a, h_a, d_a, m_a} !== 11'd0) begin
            errors++;
            $display("FAIL rst_at_term got c=%0d h=%b exp c=0 h=0", c_a, h_a);
        end
        tick();
        vectors++;
        if (c_a !== 8'd1) begin
            errors++;
            $display("FAIL first_after_rst got=%0d exp=1", c_a);
        end
        hits = int'(h_a);
        for (int i = 2; i <= 18; i++) begin
            tick();
            hits += int'(h_a);
        end
        en = 1'b0;
        vectors++;
        if (hits != 1 || h_a !== 1'b1 || c_a !== 8'd0) begin
            errors++;
            $display("FAIL post_rst_hits got hits=%0d h=%b c=%0d exp hits=1 h=1 c=0", hits, h_a, c_a);
        end
    endtask

    task automatic test_t1();
        do_reset();
        en = 1'b1;
        for (int i = 1; i <= 5; i++) begin
            tick();
            vectors++;
            if ({c_c, h_c, d_c, m_c} !== {8'd0, 3'b100}) begin
                errors++;
                $display("FAIL t1_auto cyc=%0d got c=%0d h=%b d=%b m=%b exp c=0 h=1 d=0 m=0",
                         i, c_c, h_c, d_c, m_c);
            end
            vectors++;
            if ({c_d, h_d, d_d, m_d} !== {8'd1, (i == 1), 1'b1, (i >= 2)}) begin
                errors++;
                $display("FAIL t1_oneshot cyc=%0d got c=%0d h=%b d=%b m=%b exp c=1 h=%b d=1 m=%b",
                         i, c_d, h_d, d_d, m_d, (i == 1), (i >= 2));
            end
        end
        en = 1'b0;
    endtask

    task automatic test_gaps();
        int         k;
        logic       eh;
        logic [7:0] ec;
        do_reset();
        k = 0;
        for (int i = 1; i <= 40; i++) begin
            en = (i % 2 == 0);
            tick();
            if (en) k++;
            ec = 8'(k % 18);
            eh = en && (k % 18 == 0);
            vectors++;
            if ({c_a, h_a} !== {ec, eh}) begin
                errors++;
                $display("FAIL gaps cyc=%0d en=%b got c=%0d h=%b exp c=%0d h=%b", i, en, c_a, h_a, ec, eh);
            end
        end
        en = 1'b0;
    endtask

    initial begin
        test_reset();
        test_auto_reload();
        test_one_shot();
        test_clear();
        test_reset_mid();
        test_t1();
        test_gaps();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule

// File: doc/some_module.md
SOME_MODULE -- requirements
Module: some_module

Interface
REQ-001 SOME_BIT_PARAM, default 0, mode select: 0 = one-shot (stop at terminal count), 1 = auto-reload (wrap to 0 at terminal count).
REQ-002 SOME_OTHER_INT_PARAM, default 16, terminal count T; legal range 1..255; any other value SHALL cause an elaboration-time error.
REQ-003 The block SHALL have one clock; reset is synchronous and active-high.
REQ-004 clk  input  1  rising-edge clock; all state changes on this edge only.
REQ-005 rst  input  1  synchronous active-high reset.
REQ-006 en  input  1  count-enable; one event counted per cycle while high.
REQ-007 clr  input  1  synchronous clear of count and status.
REQ-008 count  output  8  current event count, registered.
REQ-009 hit  output  1  one-cycle registered pulse on reaching terminal count.
REQ-010 done  output  1  level; one-shot mode terminal reached; always 0 in auto-reload mode.
REQ-011 missed  output  1  sticky; event arrived while done was high.

Function
REQ-012 Priority per edge SHALL be rst > clr > en; the lower-priority input is ignored when a higher one is active.
REQ-013 clr=1: count, hit, done and missed SHALL all be 0 on the following cycle.
REQ-014 en=0 and clr=0: count, done and missed hold; hit SHALL be 0.
REQ-015 en=1, done=0, count < T-1: count SHALL increment by 1; hit=0.
REQ-016 en=1, done=0, count == T-1, mode 1: count SHALL become 0 and hit SHALL be 1 for exactly the next cycle.
REQ-017 en=1, done=0, count == T-1, mode 0: count SHALL become T, done SHALL become 1, hit SHALL be 1 for exactly the next cycle.
REQ-018 en=1, done=1 (mode 0 only): count SHALL hold at T, hit=0, missed SHALL become 1 and stay 1 until rst or clr.
REQ-019 T=1: in mode 1, every enabled cycle SHALL produce hit and count SHALL stay 0; in mode 0, the first enabled cycle SHALL set count=1, done=1 and hit.
REQ-020 count SHALL never exceed T and never wrap through 255→0 except via the mode-1 terminal reload.
REQ-021 Back-to-back hits in mode 1 SHALL be separated by exactly T enabled cycles; gaps in en SHALL only stretch, not reset, the interval.
REQ-022 All outputs SHALL be driven directly from flops (no combinational path from inputs to outputs).

Reset
REQ-023 On rst=1 at a clock edge, count=0, hit=0, done=0, missed=0 on the following cycle, regardless of en/clr.
REQ-024 Reset asserted mid-count (including the cycle count == T-1 with en=1) SHALL suppress the hit pulse and clear all state.
REQ-025 After rst deasserts, the first enabled cycle SHALL produce count=1.

Verification
REQ-026 Mode 1, T=18: reset, en=1 for 40 cycles -> hit pulses after enabled cycles 18 and 36, count returns to 0 after each, done stays 0.
REQ-027 Mode 0, T=18: en=1 for 25 cycles -> count reaches 18, single hit after cycle 18, done=1 from then, missed=1 after cycle 19, count holds 18.
REQ-028 Mode 0, T=18 after done: clr=1 one cycle with en=1 -> count=0, done=0, missed=0, hit=0; next enabled cycle count=1.
REQ-029 Mode 1, T=18: count to 17, then assert rst together with en -> no hit, count=0; then 18 enabled cycles -> exactly one hit.
REQ-030 Mode 1, T=1 and mode 0, T=1: en=1 for 5 cycles -> hit every cycle with count=0 (mode 1); single hit, count=1, done=1, missed=1 from cycle 2 (mode 0).
REQ-031 Mode 1, T=18: en toggled 1/0 every cycle -> hit after 18 enabled cycles (36 clock cycles), count holds during en=0 cycles.
